// File: rtl/softex_slot_cache.sv
// softex_slot_cache: multi-lane slot store for softmax partial state
// (running max / denominator per lane). It allocates the lowest free slot
// first, tracks occupancy, and answers ALLOC/LOAD requests on a registered
// response channel with backpressure.

// Storage for one lane across all slots: init/write masks in, one-hot read out.
module softex_slot_lane #(
   parameter int unsigned          N_SLOTS   = 16,
   parameter int unsigned          WIDTH_MAX = 16,
   parameter int unsigned          WIDTH_DEN = 32,
   parameter logic [WIDTH_MAX-1:0] MAX_INIT  = 16'hFF80
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [N_SLOTS-1:0]   init_i,
   input  logic [N_SLOTS-1:0]   wr_i,
   input  logic [N_SLOTS-1:0]   rsel_i,
   input  logic [WIDTH_MAX-1:0] wmax_i,
   input  logic [WIDTH_DEN-1:0] wden_i,
   output logic [WIDTH_MAX-1:0] rmax_o,
   output logic [WIDTH_DEN-1:0] rden_o
);

   logic [N_SLOTS-1:0][WIDTH_MAX-1:0] max_q;
   logic [N_SLOTS-1:0][WIDTH_DEN-1:0] den_q;

   // Per-slot storage; init (alloc/free/clear) takes priority over an update.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         max_q <= {N_SLOTS{MAX_INIT}};
         den_q <= '0;
      end else begin
         for (int s = 0; s < N_SLOTS; s++) begin
            if (init_i[s]) begin
               max_q[s] <= MAX_INIT;
               den_q[s] <= '0;
            end else if (wr_i[s]) begin
               max_q[s] <= wmax_i;
               den_q[s] <= wden_i;
            end
         end
      end
   end

   // One-hot read mux; an all-zero select (out-of-range address) reads zero.
   always_comb begin
      rmax_o = '0;
      rden_o = '0;
      for (int s = 0; s < N_SLOTS; s++) begin
         if (rsel_i[s]) begin
            rmax_o = max_q[s];
            rden_o = den_q[s];
         end
      end
   end

endmodule

module softex_slot_cache #(
   parameter int unsigned          N_SLOTS   = 16,
   parameter int unsigned          NUM_LANES = 1,
   parameter int unsigned          WIDTH_MAX = 16,
   parameter int unsigned          WIDTH_DEN = 32,
   parameter int unsigned          ADDR_W    = 8,
   parameter logic [WIDTH_MAX-1:0] MAX_INIT  = 16'hFF80,
   parameter int unsigned          CNT_W     = $clog2(N_SLOTS + 1)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic                           req_valid_i,
   output logic                           req_ready_o,
   input  logic                           req_op_i,
   input  logic [ADDR_W-1:0]              req_addr_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic                           rsp_hit_o,
   output logic [ADDR_W-1:0]              rsp_addr_o,
   output logic [NUM_LANES*WIDTH_MAX-1:0] rsp_max_o,
   output logic [NUM_LANES*WIDTH_DEN-1:0] rsp_den_o,
   input  logic                           upd_valid_i,
   input  logic                           upd_op_i,
   input  logic [ADDR_W-1:0]              upd_addr_i,
   input  logic [NUM_LANES*WIDTH_MAX-1:0] upd_max_i,
   input  logic [NUM_LANES*WIDTH_DEN-1:0] upd_den_i,
   output logic                           full_o,
   output logic [CNT_W-1:0]               n_used_o
);

   if (N_SLOTS < 2) begin : g_chk_slots
      $error("softex_slot_cache: N_SLOTS must be at least 2");
   end
   if ((2 ** ADDR_W) < N_SLOTS) begin : g_chk_addr
      $error("softex_slot_cache: ADDR_W too narrow for N_SLOTS");
   end

   localparam logic [NUM_LANES*WIDTH_MAX-1:0] INIT_MAX = {NUM_LANES{MAX_INIT}};

   typedef struct packed {
      logic                                 hit;
      logic [ADDR_W-1:0]                    addr;
      logic [NUM_LANES-1:0][WIDTH_MAX-1:0]  max_v;
      logic [NUM_LANES-1:0][WIDTH_DEN-1:0]  den_v;
   } rsp_t;

   rsp_t                                rsp_q, rsp_d;
   logic                                rsp_valid_q;
   logic [N_SLOTS-1:0]                  valid_q, valid_d;
   logic [N_SLOTS-1:0]                  alloc_oh, upd_oh, rd_oh;
   logic [N_SLOTS-1:0]                  upd_wr, upd_free, init_mask;
   logic                                req_acc, alloc_found, alloc_ok, free_ok;
   logic                                load_hit, load_byp;
   logic [ADDR_W-1:0]                   alloc_idx;
   logic [CNT_W-1:0]                    n_used_q, n_used_d;
   logic                                full_q;
   logic [NUM_LANES-1:0][WIDTH_MAX-1:0] rd_max;
   logic [NUM_LANES-1:0][WIDTH_DEN-1:0] rd_den;

   // A new request may enter only when the response register is free or draining.
   assign req_ready_o = ~clear_i & (~rsp_valid_q | rsp_ready_i);
   assign req_acc     = req_valid_i & req_ready_o;

   // Lowest-index slot that is invalid at the start of the cycle.
   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      alloc_oh    = '0;
      for (int s = N_SLOTS - 1; s >= 0; s--) begin
         if (!valid_q[s]) begin
            alloc_found = 1'b1;
            alloc_idx   = ADDR_W'(s);
            alloc_oh    = '0;
            alloc_oh[s] = 1'b1;
         end
      end
   end

   // Address decode; addresses at or above N_SLOTS decode to no slot at all.
   always_comb begin
      upd_oh = '0;
      rd_oh  = '0;
      for (int s = 0; s < N_SLOTS; s++) begin
         upd_oh[s] = (upd_addr_i == ADDR_W'(s));
         rd_oh[s]  = (req_addr_i == ADDR_W'(s));
      end
   end

   // Update/free only act on slots valid before this cycle, so a slot being
   // allocated now cannot also be updated or freed.
   assign upd_wr    = {N_SLOTS{upd_valid_i & ~upd_op_i & ~clear_i}} & upd_oh & valid_q;
   assign upd_free  = {N_SLOTS{upd_valid_i &  upd_op_i & ~clear_i}} & upd_oh & valid_q;
   assign alloc_ok  = req_acc & ~req_op_i & alloc_found;
   assign free_ok   = |upd_free;
   assign init_mask = {N_SLOTS{clear_i}} | upd_free | (alloc_ok ? alloc_oh : '0);
   assign valid_d   = clear_i ? '0 : ((valid_q & ~upd_free) | (alloc_ok ? alloc_oh : '0));
   assign load_hit  = |(rd_oh & valid_q & ~upd_free);
   assign load_byp  = |(rd_oh & upd_wr);

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      softex_slot_lane #(
         .N_SLOTS   (N_SLOTS),
         .WIDTH_MAX (WIDTH_MAX),
         .WIDTH_DEN (WIDTH_DEN),
         .MAX_INIT  (MAX_INIT)
      ) u_lane (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .init_i (init_mask),
         .wr_i   (upd_wr),
         .rsel_i (rd_oh),
         .wmax_i (upd_max_i[l*WIDTH_MAX +: WIDTH_MAX]),
         .wden_i (upd_den_i[l*WIDTH_DEN +: WIDTH_DEN]),
         .rmax_o (rd_max[l]),
         .rden_o (rd_den[l])
      );
   end

   // Response payload: a same-cycle update to the loaded slot is bypassed in.
   always_comb begin
      rsp_d.hit   = 1'b0;
      rsp_d.addr  = req_addr_i;
      rsp_d.max_v = INIT_MAX;
      rsp_d.den_v = '0;
      if (!req_op_i) begin
         rsp_d.hit  = alloc_found;
         rsp_d.addr = alloc_idx;
      end else if (load_byp) begin
         rsp_d.hit   = 1'b1;
         rsp_d.max_v = upd_max_i;
         rsp_d.den_v = upd_den_i;
      end else if (load_hit) begin
         rsp_d.hit   = 1'b1;
         rsp_d.max_v = rd_max;
         rsp_d.den_v = rd_den;
      end
   end

   // Response register: load on accept, otherwise hold until consumed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_q <= 1'b0;
         rsp_q.hit   <= 1'b0;
         rsp_q.addr  <= '0;
         rsp_q.max_v <= INIT_MAX;
         rsp_q.den_v <= '0;
      end else if (req_acc) begin
         rsp_valid_q <= 1'b1;
         rsp_q       <= rsp_d;
      end else if (rsp_ready_i) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign n_used_d = clear_i ? '0 : (n_used_q + CNT_W'(alloc_ok) - CNT_W'(free_ok));

   // Valid bits and occupancy; full is registered alongside the counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q  <= '0;
         n_used_q <= '0;
         full_q   <= 1'b0;
      end else begin
         valid_q  <= valid_d;
         n_used_q <= n_used_d;
         full_q   <= (n_used_d == CNT_W'(N_SLOTS));
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_hit_o   = rsp_q.hit;
   assign rsp_addr_o  = rsp_q.addr;
   assign rsp_max_o   = rsp_q.max_v;
   assign rsp_den_o   = rsp_q.den_v;
   assign full_o      = full_q;
   assign n_used_o    = n_used_q;

endmodule

// File: tb/tb_softex_slot_cache.sv
// tb_softex_slot_cache: directed scenarios plus random traffic, checked each
// cycle against a slot-level reference model held in plain arrays.
module tb_softex_slot_cache;
   localparam int NS = 16;
   localparam int NL = 2;
   localparam int WM = 16;
   localparam int WD = 32;
   localparam int AW = 8;
   localparam int CW = 5;
   localparam logic [NL*WM-1:0] INIT_MAX = {NL{16'hFF80}};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clear, req_valid, req_op, rsp_ready, upd_valid, upd_op;
   logic [AW-1:0]    req_addr, upd_addr;
   logic [NL*WM-1:0] upd_max;
   logic [NL*WD-1:0] upd_den;
   logic             req_ready, rsp_valid, rsp_hit, full;
   logic [AW-1:0]    rsp_addr;
   logic [NL*WM-1:0] rsp_max;
   logic [NL*WD-1:0] rsp_den;
   logic [CW-1:0]    n_used;

   always #5 clk = ~clk;

   softex_slot_cache #(
      .N_SLOTS(NS), .NUM_LANES(NL), .WIDTH_MAX(WM), .WIDTH_DEN(WD), .ADDR_W(AW),
      .MAX_INIT(16'hFF80), .CNT_W(CW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_addr_i(req_addr),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit), .rsp_addr_o(rsp_addr),
      .rsp_max_o(rsp_max), .rsp_den_o(rsp_den),
      .upd_valid_i(upd_valid), .upd_op_i(upd_op), .upd_addr_i(upd_addr),
      .upd_max_i(upd_max), .upd_den_i(upd_den),
      .full_o(full), .n_used_o(n_used)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: slot contents, occupancy and the expected response register
   bit               m_val [NS];
   logic [NL*WM-1:0] m_max [NS];
   logic [NL*WD-1:0] m_den [NS];
   int               m_cnt;
   bit               e_rv, e_hit, m_fresh;
   int               e_addr;
   logic [NL*WM-1:0] e_max;
   logic [NL*WD-1:0] e_den;

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_val[i] = 1'b0; m_max[i] = INIT_MAX; m_den[i] = '0;
      end
      m_cnt = 0; e_rv = 1'b0; e_hit = 1'b0; e_addr = 0;
      e_max = INIT_MAX; e_den = '0; m_fresh = 1'b1;
   endtask

   task automatic check_outs();
      chk("rsp_valid", rsp_valid, e_rv);
      chk("n_used", n_used, m_cnt);
      chk("full", full, m_cnt == NS);
      if (e_rv || m_fresh) begin
         chk("rsp_hit", rsp_hit, e_hit);
         chk("rsp_addr", rsp_addr, e_addr);
         chk("rsp_max", rsp_max, e_max);
         chk("rsp_den", rsp_den, e_den);
      end
   endtask

   // One clock: drive at negedge, check ready, advance model, check outputs at next negedge.
   task automatic step(input bit clr, input bit rv, input bit op, input int ra, input bit rr,
                       input bit uv, input bit uop, input int ua,
                       input logic [NL*WM-1:0] um, input logic [NL*WD-1:0] ud);
      bit rdy, acc, ua_ok, do_upd, do_free;
      int found;
      clear = clr; req_valid = rv; req_op = op; req_addr = AW'(ra); rsp_ready = rr;
      upd_valid = uv; upd_op = uop; upd_addr = AW'(ua); upd_max = um; upd_den = ud;
      #1;
      rdy = !clr && (!e_rv || rr);
      acc = rv && rdy;
      chk("req_ready", req_ready, rdy);
      ua_ok   = (ua < NS) && m_val[ua];
      do_upd  = !clr && uv && !uop && ua_ok;
      do_free = !clr && uv && uop && ua_ok;
      found = -1;
      if (acc) begin
         m_fresh = 1'b0; e_rv = 1'b1;
         e_max = INIT_MAX; e_den = '0; e_hit = 1'b0;
         if (!op) begin
            for (int i = NS - 1; i >= 0; i--) if (!m_val[i]) found = i;
            e_hit  = (found >= 0);
            e_addr = (found >= 0) ? found : 0;
         end else begin
            e_addr = ra;
            if (ra < NS && m_val[ra]) begin
               if (uv && ua == ra && !uop) begin
                  e_hit = 1'b1; e_max = um; e_den = ud;
               end else if (!(uv && ua == ra && uop)) begin
                  e_hit = 1'b1; e_max = m_max[ra]; e_den = m_den[ra];
               end
            end
         end
      end else if (rr) begin
         e_rv = 1'b0;
      end
      if (clr) begin
         for (int i = 0; i < NS; i++) begin
            m_val[i] = 1'b0; m_max[i] = INIT_MAX; m_den[i] = '0;
         end
         m_cnt = 0;
      end else begin
         if (do_upd) begin m_max[ua] = um; m_den[ua] = ud; end
         if (do_free) begin
            m_val[ua] = 1'b0; m_max[ua] = INIT_MAX; m_den[ua] = '0; m_cnt--;
         end
         if (found >= 0) begin
            m_val[found] = 1'b1; m_max[found] = INIT_MAX; m_den[found] = '0; m_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outs();
   endtask

   task automatic idle(input bit rr);
      step(0, 0, 0, 0, rr, 0, 0, 0, '0, '0);
   endtask
   task automatic alloc(input bit rr);
      step(0, 1, 0, 0, rr, 0, 0, 0, '0, '0);
   endtask
   task automatic load(input int a, input bit rr);
      step(0, 1, 1, a, rr, 0, 0, 0, '0, '0);
   endtask

   initial begin
      clear = 0; req_valid = 0; req_op = 0; req_addr = '0; rsp_ready = 1;
      upd_valid = 0; upd_op = 0; upd_addr = '0; upd_max = '0; upd_den = '0;
      model_reset();
      @(negedge clk);
      check_outs();
      rst_n = 1'b1;

      // fill every slot, then one more ALLOC must miss
      for (int i = 0; i < NS; i++) alloc(1);
      chk("full_after_fill", full, 1'b1);
      alloc(1);
      chk("alloc_miss_hit", rsp_hit, 1'b0);
      idle(1);

      // two-lane update then load back; load an unallocated slot
      step(1, 0, 0, 0, 1, 0, 0, 0, '0, '0);
      alloc(1);
      step(0, 0, 0, 0, 1, 1, 0, 0, {16'h3F80, 16'h4000}, {32'h3F800000, 32'h40000000});
      load(0, 1);
      chk("load0_max", rsp_max, 32'h3F80_4000);
      load(5, 1);
      chk("load5_hit", rsp_hit, 1'b0);

      // same-cycle LOAD+UPDATE bypass and LOAD+FREE on slot 3
      for (int i = 0; i < 3; i++) alloc(1);
      step(0, 1, 1, 3, 1, 1, 0, 3, {16'h4040, 16'h4040}, {32'h1, 32'h2});
      chk("bypass_max", rsp_max, {16'h4040, 16'h4040});
      step(0, 1, 1, 3, 1, 1, 1, 3, '0, '0);
      chk("load_free_hit", rsp_hit, 1'b0);
      load(200, 1);

      // fill, then ALLOC alongside FREE 7 misses; the next ALLOC gets 7
      for (int i = 0; i < NS; i++) alloc(1);
      step(0, 1, 0, 0, 1, 1, 1, 7, '0, '0);
      chk("alloc_with_free_hit", rsp_hit, 1'b0);
      alloc(1);
      chk("realloc_addr", rsp_addr, 8'd7);

      // backpressure: response held, requests stalled, release accepts at once
      load(2, 1);
      for (int i = 0; i < 5; i++) load(4, 0);
      load(4, 1);
      load(9, 0);
      load(9, 0);
      // async reset mid-hold
      clear = 0; req_valid = 0; rsp_ready = 0; upd_valid = 0;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;

      // clear with a pending response
      for (int i = 0; i < 4; i++) alloc(1);
      load(1, 0);
      step(1, 1, 1, 2, 0, 1, 0, 2, '1, '1);
      chk("clear_n_used", n_used, 0);
      idle(1);
      for (int i = 0; i < 4; i++) load(i, 1);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         int r1, r2;
         r1 = $urandom_range(0, 19); r1 = (r1 < 18) ? r1 : 200;
         r2 = $urandom_range(0, 19); r2 = (r2 < 18) ? r2 : 200;
         step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
              r1, $urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 9) < 4,
              r2, {$urandom}, {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/softex_slot_cache.md
Name: softex_slot_cache

Overview:
- Parametrised multi-lane slot store for softmax partial state: per-lane running maximum and denominator, indexed by slot address.
- Successor to the fixed single-slot-regfile scheme: configurable slot count and lane count, first-free allocation, occupancy tracking and a registered response channel with backpressure.
- Sits between the softex controller (ALLOC/LOAD requests, UPDATE/FREE ops) and the datapath max/denominator load ports.

Parameters:
- N_SLOTS, 16, number of slots (≥2)
- NUM_LANES, 1, lanes per slot
- WIDTH_MAX, 16, width of one lane maximum (FP16ALT)
- WIDTH_DEN, 32, width of one lane denominator (FP32)
- ADDR_W, 8, slot address width; elaboration error unless 2**ADDR_W ≥ N_SLOTS
- MAX_INIT, 16'hFF80, init value of every lane maximum (FP16ALT −inf)
- CNT_W, $clog2(N_SLOTS+1), occupancy counter width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous invalidate-all
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  1  0=ALLOC, 1=LOAD
- req_addr_i  in  ADDR_W  LOAD address (ignored for ALLOC)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_hit_o  out  1  ALLOC succeeded / LOAD slot valid
- rsp_addr_o  out  ADDR_W  allocated or loaded slot address
- rsp_max_o  out  NUM_LANES*WIDTH_MAX  lane maxima, lane 0 in LSBs
- rsp_den_o  out  NUM_LANES*WIDTH_DEN  lane denominators, lane 0 in LSBs
- upd_valid_i  in  1  update op valid (always accepted)
- upd_op_i  in  1  0=UPDATE, 1=FREE
- upd_addr_i  in  ADDR_W  update target slot
- upd_max_i  in  NUM_LANES*WIDTH_MAX  new maxima
- upd_den_i  in  NUM_LANES*WIDTH_DEN  new denominators
- full_o  out  1  all slots valid
- n_used_o  out  CNT_W  number of valid slots

Behaviour:
- Reset values:
  - All valid bits 0; slot maxima = MAX_INIT; denominators 0.
  - rsp_valid_o=0; rsp_hit_o=0; rsp_addr_o=0; rsp_max_o=MAX_INIT per lane; rsp_den_o=0.
  - n_used_o=0; full_o=0.
  - Reset mid-transaction drops any pending response.
- Handshake:
  - req_ready_o = !clear_i & (!rsp_valid_o | rsp_ready_i).
  - A request is accepted when req_valid_i & req_ready_o.
  - The response is registered: rsp_valid_o rises the cycle after acceptance.
  - rsp_* are held stable until rsp_valid_o & rsp_ready_i.
  - Back-to-back accepts give one response per cycle.
- ALLOC:
  - Selects the lowest-index slot that was invalid at the start of the cycle.
  - Sets its valid bit and writes MAX_INIT/0 into all lanes.
  - Response: hit=1, addr=index, data=init values.
  - If all slots are valid: hit=0, addr=0, data=init values, no state change.
- LOAD:
  - hit = valid[req_addr_i].
  - Data is the stored slot contents if hit, else init values; addr echoes req_addr_i.
  - req_addr_i ≥ N_SLOTS gives hit=0.
- UPDATE:
  - Writes upd_max_i/upd_den_i to a valid in-range slot.
  - Silently ignored if the slot is invalid or out of range.
- FREE:
  - Clears the valid bit of an in-range slot.
  - Data is reset to init values.
  - FREE of an invalid slot has no effect.
- Simultaneous events:
  - LOAD and UPDATE to the same address: the response carries the updated data (write bypass).
  - LOAD and FREE to the same address: the response has hit=0 and init data.
  - ALLOC and FREE in the same cycle: ALLOC does not see the freed slot; it becomes allocatable next cycle.
  - UPDATE to the slot being allocated that cycle is ignored, because the slot was invalid before the cycle.
- clear_i:
  - Invalidates all slots, resets data and sets n_used_o=0.
  - Overrides same-cycle update ops.
  - A pending response stays valid and unchanged.
- Occupancy:
  - n_used_o is +1 on a successful ALLOC and −1 on a FREE of a valid slot; both in one cycle give net 0.
  - full_o = (n_used_o == N_SLOTS), registered with the counter.
  - The counter never wraps: bounded by the valid-bit logic.

Test Plan:
- Reset, then 16 ALLOCs with rsp_ready_i=1 (N_SLOTS=16) -> responses addr 0..15, hit=1, one per cycle. full_o=1 and n_used_o=16 after the last accept. A 17th ALLOC returns hit=0, addr=0.
- NUM_LANES=2: ALLOC slot 0; UPDATE slot 0 with max={16'h3F80,16'h4000}, den={32'h3F800000,32'h40000000}; LOAD 0 -> hit=1 with exactly those values. LOAD 5 (never allocated) -> hit=0, max=FF80 per lane, den=0.
- LOAD and UPDATE to slot 3 in the same cycle, UPDATE max=16'h4040 -> response max=16'h4040. FREE 3 with LOAD 3 in the same cycle -> hit=0, n_used_o decrements by 1.
- Fill all slots, then FREE 7 together with an ALLOC in the same cycle -> that ALLOC returns hit=0. The next ALLOC returns addr=7, and n_used_o returns to 16.
- Hold rsp_ready_i=0 for 5 cycles after an accepted LOAD -> rsp_valid_o=1 with stable data, req_ready_o=0. Release -> same-cycle acceptance of the next request. Assert rst_ni=0 mid-hold -> all outputs at reset values.
- With 4 slots valid and a response pending, pulse clear_i -> n_used_o=0, full_o=0, req_ready_o=0 that cycle, pending response unchanged. A subsequent LOAD of any of the 4 slots -> hit=0.
